pipeline_interlock: RTL
=======================

Name: pipeline_interlock

Overview:
- Hazard and stall controller for the 5-stage pipeline. It is the producing end of the pipeline-register control signals that the EX-stage forwarding logic depends on.
- Detects load-use hazards and inserts a bubble into ID/EX, since forwarding alone cannot resolve them.
- Flushes IF/ID and ID/EX on a taken branch.
- Freezes the whole pipeline while a data-memory access waits for acknowledge, using a req/ack handshake with timeout.

Parameters:
REG_NUM_WIDTH, 5, register-number width (matches `RegNumPath).
MEM_TIMEOUT, 16, max wait cycles for dmemAck before abort; must be ≥2.
WAIT_CNT_WIDTH, 5, width of the wait counter; must satisfy 2^WAIT_CNT_WIDTH > MEM_TIMEOUT.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous, active-low reset.
idexMemRdEnable  input  1  instruction in EX is a load.
idexRDOut  input  REG_NUM_WIDTH  load destination register.
ifidRSOut  input  REG_NUM_WIDTH  rs of the instruction in ID.
ifidRTOut  input  REG_NUM_WIDTH  rt of the instruction in ID.
ifidUsesRT  input  1  ID instruction reads rt as a source.
exBranchTaken  input  1  branch resolved taken in EX.
dmemReq  input  1  MEM stage issues a data-memory access this cycle.
dmemAck  input  1  data memory completes the access.
pcWrEnable  output  1  PC update enable.
ifidWrEnable  output  1  IF/ID register write enable.
idexWrEnable  output  1  ID/EX register write enable.
exmemWrEnable  output  1  EX/MEM register write enable.
ifidFlush  output  1  load NOP into IF/ID.
idexFlush  output  1  load bubble into ID/EX.
memwbFlush  output  1  load bubble into MEM/WB.
memError  output  1  sticky flag: memory timeout occurred.

Behaviour:
- FSM states: RUN and MEM_WAIT; state register plus wait counter waitCnt.
- Reset (rst=0, asynchronous):
  - state=RUN, waitCnt=0, memError=0.
  - All write enables 0 and all flushes 0 while rst is low.
- Outputs are combinational from state and inputs, with zero-cycle latency.
- Default in RUN: all write enables 1, all flushes 0.
- Priority, highest first: memory freeze > branch flush > load-use stall.
- Memory freeze (RUN):
  - Condition: dmemReq=1 and dmemAck=0.
  - Outputs this cycle: pc, ifid, idex and exmem write enables = 0; memwbFlush=1.
  - Next state MEM_WAIT, waitCnt←1.
  - dmemReq with dmemAck in the same cycle is a single-cycle access: no freeze, state stays RUN.
- MEM_WAIT:
  - Same freeze outputs as above. waitCnt increments each cycle.
  - On dmemAck=1: freeze is released in the same cycle (memwbFlush=0, enables 1, branch and load-use rules apply); next state RUN, waitCnt←0.
  - If dmemAck=0 and waitCnt==MEM_TIMEOUT: memError←1 (sticky until reset); next state RUN; the access is abandoned.
  - dmemReq is ignored while in MEM_WAIT.
- Branch flush (RUN, no freeze, exBranchTaken=1):
  - ifidFlush=1, idexFlush=1, all enables 1, for exactly one cycle.
  - Load-use is suppressed, because the ID instruction is squashed.
- Branch held during a freeze: the branch instruction stays in EX, and the flush applies on the first unfrozen cycle.
- Load-use stall (RUN, no freeze, no branch):
  - Condition: idexMemRdEnable && idexRDOut!=0 && (idexRDOut==ifidRSOut || (ifidUsesRT && idexRDOut==ifidRTOut)).
  - Outputs: pcWrEnable=0, ifidWrEnable=0, idexFlush=1.
  - The stall self-clears after one cycle as the load advances.
  - A register-0 destination never stalls.
- Reset mid-wait: returns immediately to RUN with the counter cleared.

Optional Feature:
- Macro: INTERLOCK_PERF_EN.
- When defined:
  - Adds outputs stallCycles and flushCount, each 32 bits.
  - stallCycles increments on every cycle with pcWrEnable=0 while rst=1.
  - flushCount increments on every branch-flush cycle.
  - Both counters saturate at 0xFFFFFFFF and clear on reset.
- When undefined: the ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package:
  - State enum (RUN, MEM_WAIT).
  - `RegNumPath.
  - Constant for register 0.
  - Default MEM_TIMEOUT constant.
- Natural sub-module: load_use_detect, a combinational comparator producing the stall request. The FSM and counters stay in the top.

Test Plan:
- idexMemRdEnable=1, idexRDOut=5, ifidRSOut=5 → one cycle with pcWrEnable=0, ifidWrEnable=0, idexFlush=1; next cycle (idexMemRdEnable=0) all enables 1.
- idexMemRdEnable=1, idexRDOut=0, ifidRSOut=0 → no stall; idexRDOut=7, ifidRTOut=7, ifidUsesRT=0 → no stall.
- exBranchTaken=1 together with a load-use match → ifidFlush=1, idexFlush=1, pcWrEnable=1 for one cycle.
- dmemReq=1, dmemAck=0 for 3 cycles, then dmemAck=1 → enables 0 and memwbFlush=1 for 3 cycles, released on the ack cycle, then RUN.
- dmemAck held 0 with MEM_TIMEOUT=16 → freeze lasts 17 cycles, memError=1 thereafter; rst pulse low mid-wait → memError=0, state RUN, and enables 0 while rst is low.

Source files
------------

// File: rtl/pipeline_interlock_pkg.sv
// Shared types and constants for the pipeline interlock (hazard/stall/freeze control).
// Register-number slice used across the datapath is exported as `RegNumPath.
`ifndef RegNumPath
`define RegNumPath 4:0
`endif

package pipeline_interlock_pkg;

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } ilState_t;

   typedef logic [`RegNumPath] regNum_t;

   localparam int REG_NUM_W       = 5;
   localparam int REG_ZERO        = 0;
   localparam int MEM_TIMEOUT_DEF = 16;

endpackage

// File: rtl/pipeline_interlock_load_use.sv
// Load-use hazard comparator: requests a one-cycle stall when the ID instruction
// sources the destination of a load currently in EX. Register 0 never hazards.
module load_use_detect
   import pipeline_interlock_pkg::*;
#(
   parameter int REG_NUM_WIDTH = REG_NUM_W
) (
   input  logic                     memRdEnable,
   input  logic [REG_NUM_WIDTH-1:0] rdNum,
   input  logic [REG_NUM_WIDTH-1:0] rsNum,
   input  logic [REG_NUM_WIDTH-1:0] rtNum,
   input  logic                     usesRt,
   output logic                     stallReq
);

   logic rdNonZero;
   logic rsMatch;
   logic rtMatch;

   assign rdNonZero = (rdNum != REG_NUM_WIDTH'(REG_ZERO));
   assign rsMatch   = (rdNum == rsNum);
   assign rtMatch   = usesRt && (rdNum == rtNum);
   assign stallReq  = memRdEnable && rdNonZero && (rsMatch || rtMatch);

endmodule

// File: rtl/pipeline_interlock.sv
// Hazard/stall controller: memory freeze > branch flush > load-use stall.
// Define INTERLOCK_PERF_EN to add saturating stallCycles/flushCount counters.
module pipeline_interlock
   import pipeline_interlock_pkg::*;
#(
   parameter int REG_NUM_WIDTH  = REG_NUM_W,
   parameter int MEM_TIMEOUT    = MEM_TIMEOUT_DEF,
   parameter int WAIT_CNT_WIDTH = 5
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     idexMemRdEnable,
   input  logic [REG_NUM_WIDTH-1:0] idexRDOut,
   input  logic [REG_NUM_WIDTH-1:0] ifidRSOut,
   input  logic [REG_NUM_WIDTH-1:0] ifidRTOut,
   input  logic                     ifidUsesRT,
   input  logic                     exBranchTaken,
   input  logic                     dmemReq,
   input  logic                     dmemAck,
   output logic                     pcWrEnable,
   output logic                     ifidWrEnable,
   output logic                     idexWrEnable,
   output logic                     exmemWrEnable,
   output logic                     ifidFlush,
   output logic                     idexFlush,
   output logic                     memwbFlush,
   output logic                     memError
`ifdef INTERLOCK_PERF_EN
   ,
   output logic [31:0]              stallCycles,
   output logic [31:0]              flushCount
`endif
);

   ilState_t                  state;
   ilState_t                  stateNext;
   logic [WAIT_CNT_WIDTH-1:0] waitCnt;
   logic [WAIT_CNT_WIDTH-1:0] waitCntNext;
   logic                      memErrorNext;
   logic                      freeze;
   logic                      stallReq;

   load_use_detect #(
      .REG_NUM_WIDTH(REG_NUM_WIDTH)
   ) uLoadUse (
      .memRdEnable(idexMemRdEnable),
      .rdNum      (idexRDOut),
      .rsNum      (ifidRSOut),
      .rtNum      (ifidRTOut),
      .usesRt     (ifidUsesRT),
      .stallReq   (stallReq)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= RUN;
         waitCnt  <= '0;
         memError <= 1'b0;
      end else begin
         state    <= stateNext;
         waitCnt  <= waitCntNext;
         memError <= memErrorNext;
      end
   end

   // A same-cycle ack is a single-cycle access and never enters MEM_WAIT.
   always_comb begin
      stateNext    = state;
      waitCntNext  = waitCnt;
      memErrorNext = memError;
      freeze       = 1'b0;
      case (state)
         RUN: begin
            if (dmemReq && !dmemAck) begin
               freeze      = 1'b1;
               stateNext   = MEM_WAIT;
               waitCntNext = WAIT_CNT_WIDTH'(1);
            end
         end
         MEM_WAIT: begin
            if (dmemAck) begin
               stateNext   = RUN;
               waitCntNext = '0;
            end else begin
               freeze = 1'b1;
               if (waitCnt == WAIT_CNT_WIDTH'(MEM_TIMEOUT)) begin
                  memErrorNext = 1'b1;
                  stateNext    = RUN;
                  waitCntNext  = '0;
               end else begin
                  waitCntNext = waitCnt + 1'b1;
               end
            end
         end
         default: begin
            stateNext   = RUN;
            waitCntNext = '0;
         end
      endcase
   end

   // A held branch stays in EX, so its flush lands on the first unfrozen cycle.
   always_comb begin
      pcWrEnable    = 1'b1;
      ifidWrEnable  = 1'b1;
      idexWrEnable  = 1'b1;
      exmemWrEnable = 1'b1;
      ifidFlush     = 1'b0;
      idexFlush     = 1'b0;
      memwbFlush    = 1'b0;
      if (!rst) begin
         pcWrEnable    = 1'b0;
         ifidWrEnable  = 1'b0;
         idexWrEnable  = 1'b0;
         exmemWrEnable = 1'b0;
      end else if (freeze) begin
         pcWrEnable    = 1'b0;
         ifidWrEnable  = 1'b0;
         idexWrEnable  = 1'b0;
         exmemWrEnable = 1'b0;
         memwbFlush    = 1'b1;
      end else if (exBranchTaken) begin
         ifidFlush = 1'b1;
         idexFlush = 1'b1;
      end else if (stallReq) begin
         pcWrEnable   = 1'b0;
         ifidWrEnable = 1'b0;
         idexFlush    = 1'b1;
      end
   end

`ifdef INTERLOCK_PERF_EN
   function automatic logic [31:0] satInc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stallCycles <= '0;
         flushCount  <= '0;
      end else begin
         if (!pcWrEnable) stallCycles <= satInc(stallCycles);
         if (ifidFlush)   flushCount  <= satInc(flushCount);
      end
   end
`endif

endmodule
